counter_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit loadable/incrementing counter among `NREQ` requesters. Each requester asks for a load (with data) or an increment. The block grants one requester at a time, drives the counter's `ld`/`inc`/`data_in` controls for exactly one cycle, captures the resulting count and returns it with an acknowledge pulse. It sits between client logic and the counter instance; the counter's own reset is not driven by this block.

---
 rtl/counter_arbiter_if.sv | 28 ++
 rtl/counter_arbiter.sv | 137 +++++++++++++
 tb/tb_counter_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_if.sv
// Request/response and counter-control bundle for counter_arbiter.
// slave = arbiter view, master = client/counter view.
interface counter_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   op;
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      rdata;
    logic              busy;
    logic              ctr_ld;
    logic              ctr_inc;
    logic [W-1:0]      ctr_data;
    logic [W-1:0]      ctr_q;

    modport master (
        output req, op, wdata, ctr_q,
        input  gnt, ack, rdata, busy, ctr_ld, ctr_inc, ctr_data
    );

    modport slave (
        input  req, op, wdata, ctr_q,
        output gnt, ack, rdata, busy, ctr_ld, ctr_inc, ctr_data
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin sequencer sharing one loadable/incrementing counter among NREQ clients.
// Optional CTR_ARB_PRIO0_EN: requester 0 always wins and does not move the pointer.
module counter_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    counter_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_ACK} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic [W-1:0]    r_rdata;
    logic            r_busy;
    logic            r_ctr_ld;
    logic            r_ctr_inc;
    logic [W-1:0]    r_ctr_data;

    logic            w_found;
    logic            w_prio0;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_lat;
    logic [NREQ-1:0] w_gnt_d;
    logic [NREQ-1:0] w_ack_d;
    logic            w_ld_d;
    logic            w_inc_d;
    logic [W-1:0]    w_data_d;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // First requester at or after the pointer, searching upward modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req[wrap_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = wrap_idx(r_ptr, k);
            end
        end
`ifdef CTR_ARB_PRIO0_EN
        w_prio0 = bus.req[0];
`else
        w_prio0 = 1'b0;
`endif
        if (w_prio0) begin
            w_found   = 1'b1;
            w_sel     = '0;
            w_ptr_nxt = r_ptr;
        end else begin
            w_ptr_nxt = wrap_idx(w_sel, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state plus the next value of every registered output.
    always_comb begin
        w_next   = r_state;
        w_lat    = 1'b0;
        w_gnt_d  = '0;
        w_ack_d  = '0;
        w_ld_d   = 1'b0;
        w_inc_d  = 1'b0;
        w_data_d = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next         = S_ISSUE;
                    w_lat          = 1'b1;
                    w_gnt_d[w_sel] = 1'b1;
                    w_ld_d         = bus.op[w_sel];
                    w_inc_d        = !bus.op[w_sel];
                    if (bus.op[w_sel]) w_data_d = bus.wdata[w_sel*W +: W];
                end
            end
            S_ISSUE: w_next = S_CAPT;
            S_CAPT: begin
                w_next         = S_ACK;
                w_ack_d[r_idx] = 1'b1;
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_ctr_ld   <= 1'b0;
            r_ctr_inc  <= 1'b0;
            r_ctr_data <= '0;
        end else begin
            r_gnt      <= w_gnt_d;
            r_ack      <= w_ack_d;
            r_busy     <= (w_next != S_IDLE);
            r_ctr_ld   <= w_ld_d;
            r_ctr_inc  <= w_inc_d;
            r_ctr_data <= w_data_d;
            if (r_state == S_CAPT) r_rdata <= bus.ctr_q;
            if (w_lat) begin
                r_idx <= w_sel;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.ack      = r_ack;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign bus.ctr_ld   = r_ctr_ld;
    assign bus.ctr_inc  = r_ctr_inc;
    assign bus.ctr_data = r_ctr_data;
endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural 8-bit counter on the control side.
module tb_counter_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic clk;
    logic rst;
    logic ctr_rst;
    logic [W-1:0] cq;
    int total;
    int bad;
    int cyc;

    counter_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    counter_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ctr_rst)          cq <= '0;
        else if (bus.ctr_ld)  cq <= bus.ctr_data;
        else if (bus.ctr_inc) cq <= cq + 8'd1;
    end
    assign bus.ctr_q = cq;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Steps at least once, then until an ack appears or the budget expires.
    task automatic wait_ack(output int n, output int incs);
        n = 0;
        incs = 0;
        do begin
            step();
            n++;
            if (bus.ctr_inc === 1'b1) incs++;
        end while (bus.ack === '0 && n < 12);
    endtask

    task automatic test_reset;
        rst = 1'b1; ctr_rst = 1'b1;
        bus.req = '0; bus.op = '0; bus.wdata = '0;
        step(); step();
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", bus.gnt); end
        total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL rst_ack got=%b exp=0000", bus.ack); end
        total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", bus.rdata); end
        total++; if ({bus.busy, bus.ctr_ld, bus.ctr_inc} !== 3'b000) begin bad++; $display("FAIL rst_ctl got=%b exp=000", {bus.busy, bus.ctr_ld, bus.ctr_inc}); end
        total++; if (bus.ctr_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.ctr_data); end
        rst = 1'b0; ctr_rst = 1'b0;
        step();
    endtask

    task automatic test_single_load;
        bus.req[1] = 1'b1; bus.op[1] = 1'b1; bus.wdata[15:8] = 8'h5A;
        step();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL ld_gnt got=%b exp=0010", bus.gnt); end
        total++; if ({bus.ctr_ld, bus.ctr_inc} !== 2'b10) begin bad++; $display("FAIL ld_strobe got=%b exp=10", {bus.ctr_ld, bus.ctr_inc}); end
        total++; if (bus.ctr_data !== 8'h5A) begin bad++; $display("FAIL ld_data got=%h exp=5a", bus.ctr_data); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ld_busy got=%b exp=1", bus.busy); end
        step();
        total++; if ({bus.gnt, bus.ctr_ld, bus.ctr_inc} !== 6'b0) begin bad++; $display("FAIL capt_quiet got=%b exp=000000", {bus.gnt, bus.ctr_ld, bus.ctr_inc}); end
        step();
        total++; if (bus.ack !== 4'b0010) begin bad++; $display("FAIL ld_ack got=%b exp=0010", bus.ack); end
        total++; if (bus.rdata !== 8'h5A) begin bad++; $display("FAIL ld_rdata got=%h exp=5a", bus.rdata); end
        bus.req[1] = 1'b0;
        step();
        total++; if ({bus.ack, bus.busy} !== 5'b0) begin bad++; $display("FAIL ld_done got=%b exp=00000", {bus.ack, bus.busy}); end
    endtask

    task automatic test_wrap;
        int n, incs;
        bus.req[2] = 1'b1; bus.op[2] = 1'b1; bus.wdata[23:16] = 8'hFF;
        wait_ack(n, incs);
        total++; if (bus.ack !== 4'b0100 || bus.rdata !== 8'hFF) begin bad++; $display("FAIL wrap_load got=%b/%h exp=0100/ff", bus.ack, bus.rdata); end
        bus.req[2] = 1'b0;
        step();
        bus.req[2] = 1'b1; bus.op[2] = 1'b0;
        wait_ack(n, incs);
        total++; if (bus.ack !== 4'b0100 || bus.rdata !== 8'h00) begin bad++; $display("FAIL wrap_inc got=%b/%h exp=0100/00", bus.ack, bus.rdata); end
        total++; if (incs !== 1) begin bad++; $display("FAIL wrap_inc_pulses got=%0d exp=1", incs); end
        bus.req[2] = 1'b0;
        step();
    endtask

    task automatic test_round_robin;
        int n, incs, last;
        logic [NREQ-1:0] exp_ack;
        logic [W-1:0] exp_rd;
        bus.req[0] = 1'b1; bus.op[0] = 1'b1; bus.wdata[7:0] = 8'h10;
        wait_ack(n, incs);
        bus.req = '0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        bus.req = 4'b1111; bus.op = 4'b0000;
        last = 0;
        for (int t = 0; t < 5; t++) begin
            wait_ack(n, incs);
            exp_ack = 4'b0001 << (t % 4);
            exp_rd  = 8'h11 + 8'(t);
            total++; if (bus.ack !== exp_ack || bus.rdata !== exp_rd) begin bad++; $display("FAIL rr_%0d got=%b/%h exp=%b/%h", t, bus.ack, bus.rdata, exp_ack, exp_rd); end
            if (t > 0) begin
                total++; if (cyc - last !== 4) begin bad++; $display("FAIL rr_gap_%0d got=%0d exp=4", t, cyc - last); end
            end
            last = cyc;
        end
        bus.req = '0;
        step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        int n, incs;
        bus.req[1] = 1'b1; bus.op[1] = 1'b1; bus.wdata[15:8] = 8'h33;
        step();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL rm_gnt got=%b exp=0010", bus.gnt); end
        step();
        rst = 1'b1; bus.req = '0;
        step();
        total++; if ({bus.gnt, bus.ack, bus.busy, bus.ctr_ld, bus.ctr_inc} !== 11'b0) begin bad++; $display("FAIL rm_outs got=%b exp=0", {bus.gnt, bus.ack, bus.busy, bus.ctr_ld, bus.ctr_inc}); end
        total++; if ({bus.rdata, bus.ctr_data} !== 16'h0000) begin bad++; $display("FAIL rm_data got=%h exp=0000", {bus.rdata, bus.ctr_data}); end
        rst = 1'b0;
        bus.req = 4'b1111; bus.op = 4'b0000;
        step();
        total++; if (bus.gnt !== 4'b0001 || bus.ack !== 4'b0000) begin bad++; $display("FAIL rm_regrant got=%b/%b exp=0001/0000", bus.gnt, bus.ack); end
        bus.req = '0;
        wait_ack(n, incs);
        total++; if (bus.ack !== 4'b0001 || bus.rdata !== 8'h34) begin bad++; $display("FAIL rm_ack got=%b/%h exp=0001/34", bus.ack, bus.rdata); end
        step();
    endtask

    task automatic test_drop;
        bus.req = 4'b1000; bus.op = 4'b0000;
        step();
        total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL drop_gnt got=%b exp=1000", bus.gnt); end
        bus.req = '0;
        step(); step();
        total++; if (bus.ack !== 4'b1000 || bus.rdata !== 8'h35) begin bad++; $display("FAIL drop_ack got=%b/%h exp=1000/35", bus.ack, bus.rdata); end
        step(); step();
        total++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL drop_regrant got=%b/%b exp=0000/0", bus.gnt, bus.busy); end
    endtask

    task automatic test_prio;
        int n;
        logic [NREQ-1:0] exp_g [4];
`ifdef CTR_ARB_PRIO0_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif
        rst = 1'b1; step(); rst = 1'b0;
        bus.req = 4'b0101; bus.op = 4'b0000;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin step(); n++; end while (bus.gnt === '0 && n < 8);
            total++; if (bus.gnt !== exp_g[t]) begin bad++; $display("FAIL prio_%0d got=%b exp=%b", t, bus.gnt, exp_g[t]); end
        end
        bus.req = '0;
        step(); step(); step(); step();
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        test_reset();
        test_single_load();
        test_wrap();
        test_round_robin();
        test_reset_mid();
        test_drop();
        test_prio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
